// File: rtl/mv_mult_pkg.sv
// Shared types and helpers for the matrix-vector multiply engine.
package mv_mult_pkg;
    typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, DONE} state_t;

    localparam logic WR_SEL_A = 1'b0;
    localparam logic WR_SEL_X = 1'b1;

    function automatic int acc_width(input int dw, input int n);
        return 2 * dw + $clog2(n);
    endfunction

    // Fill bit used when widening a value: its MSB in signed mode, else zero.
    function automatic logic ext_fill(input logic msb, input logic sgn);
        return msb & sgn;
    endfunction
endpackage

// File: rtl/mv_mult_engine_mac_lane.sv
// One multiply-accumulate lane: exact product, widened into an ACC_W accumulator.
module mac_lane
    import mv_mult_pkg::*;
#(
    parameter int DW     = 8,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [DW-1:0]    a,
    input  logic [DW-1:0]    x,
    output logic [ACC_W-1:0] acc
);
    logic signed [DW:0]     a_ext;
    logic signed [DW:0]     x_ext;
    logic signed [2*DW-1:0] prod;
    logic [ACC_W-1:0]       prod_ext;

    // One extra operand bit lets a single signed multiplier cover both modes.
    assign a_ext    = {ext_fill(a[DW-1], SIGNED), a};
    assign x_ext    = {ext_fill(x[DW-1], SIGNED), x};
    assign prod     = a_ext * x_ext;
    assign prod_ext = {{(ACC_W - 2 * DW){ext_fill(prod[2*DW-1], SIGNED)}}, prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + prod_ext;
    end
endmodule

// File: rtl/mv_mult_engine.sv
// Matrix-vector multiplier y = A*x: LANES rows per group, results streamed one row per beat.
module mv_mult_engine
    import mv_mult_pkg::*;
#(
    parameter int DW     = 8,
    parameter int N      = 10,
    parameter int M      = 4,
    parameter int LANES  = 2,
    parameter bit SIGNED = 1'b0,
    parameter int ACC_W  = acc_width(DW, N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  wr_sel,
    input  logic [$clog2(M*N)-1:0] wr_addr,
    input  logic [DW-1:0]         wr_data,
    input  logic                  start,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_W-1:0]      out_data,
    output logic [$clog2(M)-1:0]  out_row,
    output logic                  done
);
    localparam int AW = $clog2(M * N);
    localparam int XW = $clog2(N);
    localparam int RW = $clog2(M);
    localparam int GW = $clog2(M + LANES) + 1;
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [DW-1:0]    mem_a [M*N];
    logic [DW-1:0]    mem_x [N];
    logic [DW-1:0]    x_p1;
    logic [ACC_W-1:0] acc [LANES];

    state_t        state;
    logic [XW-1:0] k;
    logic [GW-1:0] g;
    logic [LW-1:0] lane;
    logic          vld_p1;
    logic          last_k;
    logic          next_active;
    logic          more_groups;
    logic          grp_start;

    assign last_k      = (k == XW'(N - 1));
    assign next_active = (int'(lane) + 1 < LANES) && (int'(g) + int'(lane) + 1 < M);
    assign more_groups = (int'(g) + LANES < M);
    assign grp_start   = ((state == IDLE || state == DONE) && start) ||
                         (state == OUT && out_valid && out_ready && !next_active && more_groups);

    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE) begin
            if (wr_sel == WR_SEL_A) begin
                if (int'(wr_addr) < M * N)
                    mem_a[wr_addr] <= wr_data;
            end else if (int'(wr_addr[XW-1:0]) < N) begin
                mem_x[wr_addr[XW-1:0]] <= wr_data;
            end
        end
    end

    // Stage p1: registered memory reads; x[k] is shared by every lane.
    always_ff @(posedge clk) begin
        x_p1 <= mem_x[k];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [AW-1:0] rd_addr;
        logic [DW-1:0] a_p1;

        // Masked lanes read a harmless address; their results are never emitted.
        assign rd_addr = (int'(g) + l < M) ? AW'((int'(g) + l) * N + int'(k)) : '0;

        always_ff @(posedge clk) begin
            a_p1 <= mem_a[rd_addr];
        end

        // Stage p2: accumulate into the lane register.
        mac_lane #(.DW(DW), .SIGNED(SIGNED), .ACC_W(ACC_W)) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (grp_start),
            .en    (vld_p1),
            .a     (a_p1),
            .x     (x_p1),
            .acc   (acc[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            k         <= '0;
            g         <= '0;
            lane      <= '0;
            vld_p1    <= 1'b0;
        end else begin
            done   <= 1'b0;
            vld_p1 <= (state == RUN);
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        g     <= '0;
                        k     <= '0;
                    end
                end
                RUN: begin
                    k <= last_k ? '0 : k + 1'b1;
                    if (last_k)
                        state <= DRAIN;
                end
                DRAIN: begin
                    state <= OUT;
                    lane  <= '0;
                end
                OUT: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= acc[lane];
                        out_row   <= RW'(int'(g) + int'(lane));
                    end else if (out_ready) begin
                        if (next_active) begin
                            lane     <= lane + 1'b1;
                            out_data <= acc[lane + 1'b1];
                            out_row  <= RW'(int'(g) + int'(lane) + 1);
                        end else begin
                            out_valid <= 1'b0;
                            lane      <= '0;
                            if (more_groups) begin
                                state <= RUN;
                                g     <= g + GW'(LANES);
                                k     <= '0;
                            end else begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mv_mult_engine.sv
// Bench for mv_mult_engine: an unsigned M=4 instance and a signed M=5 instance share all inputs.
module tb_mv_mult_engine;
    localparam int DW    = 8;
    localparam int N     = 10;
    localparam int MU    = 4;
    localparam int MS    = 5;
    localparam int LANES = 2;
    localparam int ACC_W = 20;
    localparam int AW    = 6;
    localparam int LIMIT = 3000;

    logic clk, rst_n, wr_en, wr_sel, start, out_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic busy_u, valid_u, done_u, busy_s, valid_s, done_s;
    logic [ACC_W-1:0] data_u, data_s;
    logic [1:0] row_u;
    logic [2:0] row_s;

    mv_mult_engine #(.DW(DW), .N(N), .M(MU), .LANES(LANES), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy_u), .out_valid(valid_u),
        .out_ready(out_ready), .out_data(data_u), .out_row(row_u), .done(done_u));

    mv_mult_engine #(.DW(DW), .N(N), .M(MS), .LANES(LANES), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .busy(busy_s), .out_valid(valid_s),
        .out_ready(out_ready), .out_data(data_s), .out_row(row_s), .done(done_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference memory contents; the M=4 instance simply never sees rows >= 4.
    logic [DW-1:0] ma [MS*N];
    logic [DW-1:0] mx [N];

    function automatic logic [ACC_W-1:0] model_y(input int r, input bit sgn);
        longint s = 0;
        for (int k = 0; k < N; k++) begin
            longint av = sgn ? longint'($signed(ma[r*N+k])) : longint'(ma[r*N+k]);
            longint xv = sgn ? longint'($signed(mx[k])) : longint'(mx[k]);
            s += av * xv;
        end
        return ACC_W'(s);
    endfunction

    typedef struct packed {logic [2:0] row; logic [ACC_W-1:0] data;} beat_t;
    beat_t q_u[$], q_s[$];
    int run_id = 0;
    int first_u, first_s, hs_u, hs_s, dcnt_u, dcnt_s, dcyc_u, dcyc_s;
    logic dbusy_u, dbusy_s;

    // Monitor: log accepted beats, first-valid cycle and done pulses per run.
    initial begin
        int seen = 0;
        forever begin
            @(negedge clk);
            if (run_id != seen) begin
                seen = run_id;
                q_u.delete(); q_s.delete();
                first_u = -1; first_s = -1; hs_u = -1; hs_s = -1;
                dcnt_u = 0; dcnt_s = 0; dcyc_u = -1; dcyc_s = -1;
                dbusy_u = 1'b1; dbusy_s = 1'b1;
            end
            if (rst_n) begin
                if (valid_u && first_u < 0) first_u = cyc;
                if (valid_s && first_s < 0) first_s = cyc;
                if (valid_u && out_ready) begin q_u.push_back({1'b0, row_u, data_u}); hs_u = cyc + 1; end
                if (valid_s && out_ready) begin q_s.push_back({row_s, data_s}); hs_s = cyc + 1; end
                if (done_u) begin dcnt_u++; dcyc_u = cyc; dbusy_u = busy_u; end
                if (done_s) begin dcnt_s++; dcyc_s = cyc; dbusy_s = busy_s; end
            end
        end
    end

    int total = 0, bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input bit sel, input int addr, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = AW'(addr); wr_data = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] af, input logic [DW-1:0] xf, input bit ramp, input bit rnd);
        for (int i = 0; i < MS * N; i++) begin
            ma[i] = rnd ? DW'($urandom) : af;
            wr(1'b0, i, ma[i]);
        end
        for (int k = 0; k < N; k++) begin
            mx[k] = rnd ? DW'($urandom) : (ramp ? DW'(k + 1) : xf);
            wr(1'b1, k, mx[k]);
        end
    endtask

    task automatic wait_done(input int mode);
        int n = 0;
        while (!(dcnt_u > 0 && dcnt_s > 0) && n < LIMIT) begin
            out_ready = (mode == 1) ? (($urandom % 4) != 0) : 1'b1;
            if (mode == 2 && n == 3) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_addr = '0; wr_data = ~mx[0];
            end else if (mode == 2 && n == 4) begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        chk("run_finished", 64'(n < LIMIT), 64'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic kick(output int e0);
        run_id++;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic check_run(input string tag, input int e0, input bit use_tab,
                             input logic [ACC_W-1:0] eu, input logic [ACC_W-1:0] es);
        chk({tag, "_beats_u"}, 64'(q_u.size()), 64'(MU));
        chk({tag, "_beats_s"}, 64'(q_s.size()), 64'(MS));
        for (int i = 0; i < q_u.size() && i < MU; i++) begin
            chk({tag, "_row_u"}, 64'(q_u[i].row), 64'(i));
            chk({tag, "_data_u"}, 64'(q_u[i].data), 64'(use_tab ? eu : model_y(i, 1'b0)));
        end
        for (int i = 0; i < q_s.size() && i < MS; i++) begin
            chk({tag, "_row_s"}, 64'(q_s[i].row), 64'(i));
            chk({tag, "_data_s"}, 64'(q_s[i].data), 64'(use_tab ? es : model_y(i, 1'b1)));
        end
        chk({tag, "_latency_u"}, 64'(first_u - e0), 64'(N + 2));
        chk({tag, "_latency_s"}, 64'(first_s - e0), 64'(N + 2));
        chk({tag, "_done_cnt_u"}, 64'(dcnt_u), 64'd1);
        chk({tag, "_done_cnt_s"}, 64'(dcnt_s), 64'd1);
        chk({tag, "_done_after_last_u"}, 64'(dcyc_u), 64'(hs_u));
        chk({tag, "_done_after_last_s"}, 64'(dcyc_s), 64'(hs_s));
        chk({tag, "_busy_at_done_u"}, 64'(dbusy_u), 64'd0);
        chk({tag, "_busy_at_done_s"}, 64'(dbusy_s), 64'd0);
    endtask

    typedef struct {
        logic [DW-1:0]    a_fill;
        logic [DW-1:0]    x_fill;
        bit               x_ramp;
        logic [ACC_W-1:0] exp_u;
        logic [ACC_W-1:0] exp_s;
    } vec_t;

    initial begin
        vec_t tab[4];
        int e0, n;
        tab[0] = '{8'h01, 8'h00, 1'b1, 20'd55,     20'd55};
        tab[1] = '{8'hFF, 8'hFF, 1'b0, 20'd650250, 20'd10};
        tab[2] = '{8'h80, 8'h7F, 1'b0, 20'd162560, 20'(-162560)};
        tab[3] = '{8'h80, 8'h80, 1'b0, 20'd163840, 20'd163840};

        rst_n = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_u", 64'(busy_u), 64'd0);
        chk("rst_valid_u", 64'(valid_u), 64'd0);
        chk("rst_done_u", 64'(done_u), 64'd0);
        chk("rst_data_u", 64'(data_u), 64'd0);
        chk("rst_row_u", 64'(row_u), 64'd0);
        chk("rst_busy_s", 64'(busy_s), 64'd0);
        chk("rst_valid_s", 64'(valid_s), 64'd0);
        chk("rst_data_s", 64'(data_s), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            load(tab[t].a_fill, tab[t].x_fill, tab[t].x_ramp, 1'b0);
            kick(e0);
            wait_done(0);
            check_run($sformatf("vec%0d", t), e0, 1'b1, tab[t].exp_u, tab[t].exp_s);
        end

        // Backpressure: hold row 1 for five cycles.
        load('0, '0, 1'b0, 1'b1);
        out_ready = 1'b0;
        kick(e0);
        n = 0;
        while (!(valid_u && row_u == 2'd0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_row0_seen", 64'(n < 100), 64'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 64'(valid_u), 64'd1);
            chk("bp_hold_row", 64'(row_u), 64'd1);
            chk("bp_hold_data", 64'(data_u), 64'(model_y(1, 1'b0)));
            @(posedge clk); #1;
        end
        wait_done(0);
        check_run("bp", e0, 1'b0, '0, '0);

        // Reset mid-RUN, then recompute from retained memories.
        kick(e0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy_before", 64'(busy_u), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy_u", 64'(busy_u), 64'd0);
        chk("abort_valid_u", 64'(valid_u), 64'd0);
        chk("abort_done_u", 64'(done_u), 64'd0);
        chk("abort_busy_s", 64'(busy_s), 64'd0);
        chk("abort_valid_s", 64'(valid_s), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        kick(e0);
        wait_done(0);
        check_run("after_rst", e0, 1'b0, '0, '0);

        // start and an x[0] write while busy must both be dropped.
        kick(e0);
        wait_done(2);
        check_run("busy_ign", e0, 1'b0, '0, '0);
        kick(e0);
        wait_done(0);
        check_run("x0_kept", e0, 1'b0, '0, '0);

        for (int r = 0; r < 4; r++) begin
            load('0, '0, 1'b0, 1'b1);
            kick(e0);
            wait_done(1);
            check_run($sformatf("rand%0d", r), e0, 1'b0, '0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mv_mult_engine.md
Name: mv_mult_engine

Overview:
- Parametrised matrix-vector multiplier: computes y = A·x, where A is M×N and x has N elements.
- A and x are held in internal BRAM-style memories loaded through a write port.
- LANES rows are computed in parallel by MAC lanes; results stream out one row per beat on a valid/ready port.
- Successor to the single-vector mm_wrapper datapath: adds rows, lanes, signed mode, backpressure and a done pulse.

Parameters:
- DW, 8, operand width.
- N, 10, vector length (columns of A).
- M, 4, number of rows of A.
- LANES, 2, rows computed concurrently (1..M).
- SIGNED, 0, 1 = two's-complement operands.
- ACC_W, 2*DW+$clog2(N), accumulator/result width; derived, do not override.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  memory write strobe
- wr_sel  in  1  0 = A memory, 1 = x memory
- wr_addr  in  $clog2(M*N)  A: row*N+col; x: col (upper bits ignored)
- wr_data  in  DW  write data
- start  in  1  begin computation (level sampled)
- busy  out  1  computation in progress
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  ACC_W  y[out_row]
- out_row  out  $clog2(M)  row index of out_data
- done  out  1  one-cycle pulse after final beat accepted

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, out_valid, done, out_data, out_row = 0. Memory contents not cleared.
- Clocking: all state updates on rising clk; rst_n deassertion is synchronous to clk in the system.
- FSM: IDLE -> RUN -> DRAIN -> OUT -> (RUN for next group | DONE) -> IDLE.
- IDLE:
  - start=1 sampled at edge E0: busy=1 after E0, group base row g=0.
  - start while busy is ignored.
  - wr_en is honoured only in IDLE; writes while busy are dropped.
- RUN: k=0..N-1 over N cycles. Each lane l reads A[(g+l)*N+k]; x[k] is read once and shared. Read latency is 1 cycle.
- DRAIN: final MAC performed. Accumulators are cleared at the start of each group.
- Arithmetic:
  - Products are 2*DW bits, sign- or zero-extended per SIGNED, then to ACC_W.
  - Accumulation is exact; no overflow is possible by ACC_W construction.
- Latency: first out_valid=1 exactly N+2 cycles after E0.
- OUT:
  - Emits active lanes in ascending row order, one beat per accepted handshake (out_valid & out_ready).
  - While out_ready=0, out_valid, out_data and out_row hold stable.
  - Lanes with g+l >= M are masked and never emitted, so M need not be a multiple of LANES.
- Group advance: after the last beat of a group, g += LANES. If g < M, next edge enters RUN (no idle gap beyond one cycle); else DONE.
- DONE: done=1 for exactly one cycle, busy drops to 0 the same cycle, return to IDLE. start may be accepted on the next edge.
- Throughput with out_ready=1: per group N+2 compute cycles plus active-lane beats.
- Reset mid-operation: immediate abort, outputs as reset; a subsequent start recomputes from retained memories.

Decomposition:
- Package mv_mult_pkg:
  - state_t enum (IDLE, RUN, DRAIN, OUT, DONE).
  - WR_SEL_A / WR_SEL_X constants.
  - acc_width(DW, N) function.
  - Helper for sign/zero extension.
- Sub-module mac_lane: DW operands, SIGNED, ACC_W.
  - Ports: clk, rst_n, clr, en, a, x, acc.
  - Instantiated LANES times via generate.
- A memory: LANES banks or one multi-read array (implementer's choice); must infer BRAM/LUTRAM with registered read.

Test Plan:
- Defaults; A all 1s; x[k]=k+1; start -> 4 beats, rows 0..3, each out_data=55; first out_valid at E0+12; done one cycle after beat 3.
- Defaults; A and x all 8'hFF, SIGNED=0 -> every out_data=650250 (20-bit exact, no wrap).
- SIGNED=1; A all -128; x all 127 -> every out_data=-162560 as 20-bit two's complement.
- out_ready held 0 for 5 cycles during beat of row 1 -> out_data and out_row=1 stable throughout; no beat lost or duplicated; final row order 0,1,2,3.
- rst_n pulsed low mid-RUN -> busy/out_valid/done=0 immediately; new start yields same correct results without reloading memories.
- M=5, LANES=2:
  - Third group emits only row 4.
  - start and a wr_en to x[0] issued while busy -> ignored; results unchanged; x[0] retains its old value.
